// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the interrupt sequencer.
//   irq_state_t : sequencer FSM states
//   VECTOR_W    : handler address width
//   irq_vector  : handler address for a channel id (16-bit wrap-around)
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_SAVE,
        IRQ_VECTOR,
        IRQ_RESTORE
    } irq_state_t;

    localparam int unsigned VECTOR_W = 16;

    // base + id*stride, truncated to VECTOR_W bits
    function automatic logic [VECTOR_W-1:0] irq_vector(
        input logic [VECTOR_W-1:0] base,
        input logic [VECTOR_W-1:0] id,
        input logic [VECTOR_W-1:0] stride
    );
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_sequencer_prio.sv
// irq_priority_enc: combinational lowest-index-wins priority encoder.
// Ports:
//   eligible : candidate request vector
//   found_c  : at least one bit of eligible is set
//   id_c     : index of the lowest set bit (0 when found_c=0)
module irq_priority_enc #(
    parameter  int unsigned N_IRQ = 4,
    localparam int unsigned ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] eligible,
    output logic             found_c,
    output logic [ID_W-1:0]  id_c
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        found_c = 1'b0;
        id_c    = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found_c = 1'b1;
                id_c    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: prioritised, optionally nestable interrupt sequencer beside
// the control FSM. Latches rising edges of irq, masks them, picks the lowest
// eligible channel on check, then emits take/save_state and the handler vector;
// rti pops the nesting stack and emits restore_state.
// Build option: define IRQ_NEST_EN for nesting up to NEST_DEPTH handlers;
// otherwise a single active handler blocks all channels.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   irq               : raw request lines (rising edge = request)
//   check, rti        : 1-cycle pulses from the control FSM
//   mask_we/mask_wdata: mask write (1 = enabled)
//   take, save_state  : 1-cycle pulse, handler entry
//   restore_state     : 1-cycle pulse, handler exit
//   vector_valid/vector: handler address pulse
//   busy, depth, active_id: nesting status
module irq_sequencer
    import irq_pkg::*;
#(
    parameter  int unsigned       N_IRQ         = 4,
    parameter  logic [15:0]       VECTOR_BASE   = 16'h0000,
    parameter  int unsigned       VECTOR_STRIDE = 7,
    parameter  int unsigned       NEST_DEPTH    = 4,
    parameter  logic [N_IRQ-1:0]  MASK_RESET    = '1,
    localparam int unsigned       ID_W          = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    localparam int unsigned       DEPTH_W       = $clog2(NEST_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IRQ-1:0]    irq,
    input  logic                check,
    input  logic                rti,
    input  logic                mask_we,
    input  logic [N_IRQ-1:0]    mask_wdata,
    output logic                take,
    output logic                save_state,
    output logic                restore_state,
    output logic                vector_valid,
    output logic [VECTOR_W-1:0] vector,
    output logic                busy,
    output logic [DEPTH_W-1:0]  depth,
    output logic [ID_W-1:0]     active_id
);

`ifdef IRQ_NEST_EN
    localparam int unsigned EFF_DEPTH = NEST_DEPTH;
`else
    localparam int unsigned EFF_DEPTH = 1;
`endif

    irq_state_t             state, state_d;
    logic [N_IRQ-1:0]       irq_q;
    logic [N_IRQ-1:0]       pending;
    logic [N_IRQ-1:0]       mask;
    logic [N_IRQ-1:0]       lower;
    logic [N_IRQ-1:0]       eligible;
    logic [N_IRQ-1:0]       clr;
    logic                   found;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        id_q;
    logic [ID_W-1:0]        stack [EFF_DEPTH];
    logic                   take_d;
    logic                   restore_d;
    logic                   vv_d;
    logic [VECTOR_W-1:0]    vector_d;

    // Top of stack lives in entry 0; popped entries shift in zero so this
    // reads 0 whenever the stack is empty.
    assign active_id = stack[0];

    // Eligibility: only strictly higher-priority channels may preempt.
    always_comb begin
        lower = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            lower[i] = (ID_W'(i) < active_id);
        end
        if (depth == '0) begin
            eligible = pending & mask;
        end else if (depth >= DEPTH_W'(EFF_DEPTH)) begin
            eligible = '0;
        end else begin
            eligible = pending & mask & lower;
        end
    end

    irq_priority_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .eligible (eligible),
        .found_c  (found),
        .id_c     (win_id)
    );

    // Next state and next-cycle output pulses; rti has precedence over check.
    always_comb begin
        state_d   = state;
        take_d    = 1'b0;
        restore_d = 1'b0;
        vv_d      = 1'b0;
        vector_d  = '0;
        case (state)
            IRQ_IDLE: begin
                if (rti && (depth != '0)) begin
                    state_d   = IRQ_RESTORE;
                    restore_d = 1'b1;
                end else if (check && found) begin
                    state_d = IRQ_SAVE;
                    take_d  = 1'b1;
                end
            end
            IRQ_SAVE: begin
                state_d  = IRQ_VECTOR;
                vv_d     = 1'b1;
                vector_d = irq_vector(VECTOR_BASE, VECTOR_W'(id_q), VECTOR_W'(VECTOR_STRIDE));
            end
            IRQ_VECTOR:  state_d = IRQ_IDLE;
            IRQ_RESTORE: state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
    end

    // Channel being serviced is cleared from pending at the end of SAVE.
    assign clr = (state == IRQ_SAVE) ? (N_IRQ'(1) << id_q) : '0;

    // State register and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IRQ_IDLE;
            id_q          <= '0;
            take          <= 1'b0;
            save_state    <= 1'b0;
            restore_state <= 1'b0;
            vector_valid  <= 1'b0;
            vector        <= '0;
        end else begin
            state         <= state_d;
            take          <= take_d;
            save_state    <= take_d;
            restore_state <= restore_d;
            vector_valid  <= vv_d;
            vector        <= vector_d;
            if (take_d) begin
                id_q <= win_id;
            end
        end
    end

    // Edge detection, pending latch (new edge beats clear) and mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= MASK_RESET;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr) | (irq & ~irq_q);
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // Nesting stack: push at the end of SAVE, pop at the end of RESTORE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(EFF_DEPTH); k++) begin
                stack[k] <= '0;
            end
            depth <= '0;
            busy  <= 1'b0;
        end else if (state == IRQ_SAVE) begin
            stack[0] <= id_q;
            for (int k = 1; k < int'(EFF_DEPTH); k++) begin
                stack[k] <= stack[k-1];
            end
            depth <= depth + DEPTH_W'(1);
            busy  <= 1'b1;
        end else if (state == IRQ_RESTORE) begin
            for (int k = 0; k < int'(EFF_DEPTH) - 1; k++) begin
                stack[k] <= stack[k+1];
            end
            stack[EFF_DEPTH-1] <= '0;
            depth <= depth - DEPTH_W'(1);
            busy  <= (depth != DEPTH_W'(1));
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed stimulus pushes expected
// take/vector/restore events into a queue; a monitor pops and compares.
module tb_irq_sequencer;

    localparam int unsigned N_IRQ = 4;

    typedef struct {
        int          kind;   // 0 take, 1 vector, 2 restore
        logic [15:0] vec;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IRQ-1:0] irq;
    logic             check;
    logic             rti;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             take;
    logic             save_state;
    logic             restore_state;
    logic             vector_valid;
    logic [15:0]      vector;
    logic             busy;
    logic [2:0]       depth;
    logic [1:0]       active_id;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    irq_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq           (irq),
        .check         (check),
        .rti           (rti),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .take          (take),
        .save_state    (save_state),
        .restore_state (restore_state),
        .vector_valid  (vector_valid),
        .vector        (vector),
        .busy          (busy),
        .depth         (depth),
        .active_id     (active_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [15:0] vec);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d vec %0d expected none", kind, vec);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 1 && e.vec !== vec)) begin
                failures++;
                $display("FAIL event_order: got kind %0d vec %0d expected kind %0d vec %0d",
                         kind, vec, e.kind, e.vec);
            end
        end
    endtask

    // Monitor: compare every output pulse against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (take || save_state) chk("save_with_take", save_state, take);
            if (take)               pop_cmp(0, 16'd0);
            if (vector_valid)       pop_cmp(1, vector);
            if (restore_state)      pop_cmp(2, 16'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input logic [N_IRQ-1:0] lines);
        irq = lines;
        tick();
        irq = '0;
        tick();
    endtask

    task automatic push_take(input logic [15:0] vec);
        exp_t e;
        e.kind = 0; e.vec = 16'd0; exp_q.push_back(e);
        e.kind = 1; e.vec = vec;   exp_q.push_back(e);
    endtask

    task automatic do_check();
        check = 1'b1;
        tick();
        check = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_rti(input bit expect_restore);
        exp_t e;
        if (expect_restore) begin
            e.kind = 2; e.vec = 16'd0; exp_q.push_back(e);
        end
        rti = 1'b1;
        tick();
        rti = 1'b0;
        tick();
        tick();
    endtask

    task automatic write_mask(input logic [N_IRQ-1:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; check = 1'b0; rti = 1'b0;
        mask_we = 1'b0; mask_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_take", take, 0);
        chk("rst_save", save_state, 0);
        chk("rst_restore", restore_state, 0);
        chk("rst_vvalid", vector_valid, 0);
        chk("rst_vector", vector, 0);
        chk("rst_busy", busy, 0);
        chk("rst_depth", depth, 0);
        chk("rst_active", active_id, 0);
        rst_n = 1'b1;
        tick();

        // Basic take on channel 2
        raise(4'b0100);
        push_take(16'd14);
        do_check();
        chk("basic_depth", depth, 1);
        chk("basic_busy", busy, 1);
        chk("basic_active", active_id, 2);
        do_rti(1);
        chk("ret_depth", depth, 0);
        chk("ret_busy", busy, 0);
        chk("ret_active", active_id, 0);

        // Priority: 1 beats 3, then 3 after return
        raise(4'b1010);
        push_take(16'd7);
        do_check();
        chk("prio_active", active_id, 1);
        do_rti(1);
        push_take(16'd21);
        do_check();
        chk("prio2_active", active_id, 3);
        do_rti(1);
        chk("prio_depth", depth, 0);

        // Masking holds the request pending
        write_mask(4'b1110);
        raise(4'b0001);
        do_check();
        chk("mask_depth", depth, 0);
        write_mask(4'b1111);
        push_take(16'd0);
        do_check();
        chk("unmask_depth", depth, 1);
        chk("unmask_active", active_id, 0);
        do_rti(1);

        // Nesting / single-level behaviour with channel 3 active
        raise(4'b1000);
        push_take(16'd21);
        do_check();
        chk("outer_active", active_id, 3);
`ifdef IRQ_NEST_EN
        raise(4'b0010);
        push_take(16'd7);
        do_check();
        chk("nest_depth", depth, 2);
        chk("nest_active", active_id, 1);
        raise(4'b0100);
        do_check();
        chk("nest_block_depth", depth, 2);
        do_rti(1);
        chk("unnest_depth", depth, 1);
        chk("unnest_active", active_id, 3);
        push_take(16'd14);
        do_check();
        chk("renest_depth", depth, 2);
        chk("renest_active", active_id, 2);
        do_rti(1);
        do_rti(1);
`else
        raise(4'b0001);
        do_check();
        chk("busy_block_depth", depth, 1);
        chk("busy_block_active", active_id, 3);
        do_rti(1);
        chk("single_ret_depth", depth, 0);
        push_take(16'd0);
        do_check();
        chk("late_take_active", active_id, 0);
        do_rti(1);
`endif
        chk("unwind_depth", depth, 0);

        // rti at depth 0 is ignored
        do_rti(0);
        chk("rti0_depth", depth, 0);
        chk("rti0_busy", busy, 0);

        // Reset in the middle of SAVE
        raise(4'b0100);
        check = 1'b1;
        tick();
        check = 1'b0;
        chk("midsave_take", take, 1);
        rst_n = 1'b0;
        #1;
        chk("midsave_rst_take", take, 0);
        chk("midsave_rst_save", save_state, 0);
        chk("midsave_rst_vvalid", vector_valid, 0);
        chk("midsave_rst_depth", depth, 0);
        chk("midsave_rst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        do_check();
        chk("post_rst_depth", depth, 0);

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Parametrised, prioritised, nestable interrupt sequencer. It replaces the single-level, unmasked interrupt path of the control FSM. It sits beside the control FSM: it latches edge-triggered requests, masks them and picks the winner. When the FSM pulses its check point, it drives the save_state / vector sequence, and it unwinds a nesting stack on return-from-interrupt.

Parameters:
N_IRQ, 4, number of interrupt channels; channel 0 has the highest priority
VECTOR_BASE, 16'h0000, address of the channel-0 handler
VECTOR_STRIDE, 7, address distance between consecutive handlers
NEST_DEPTH, 4, maximum number of simultaneously active handlers (≥1)
MASK_RESET, all ones, mask value after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
irq  in  N_IRQ  raw request lines; a rising edge is one request
check  in  1  1-cycle pulse from the control FSM at CHECK_INTERRUPT
rti  in  1  1-cycle pulse from the control FSM at the return-from-interrupt state
mask_we  in  1  mask write strobe
mask_wdata  in  N_IRQ  new mask; 1 = enabled
take  out  1  1-cycle pulse: the FSM must branch to its handler path
save_state  out  1  1-cycle pulse, coincident with take
restore_state  out  1  1-cycle pulse, one cycle after an accepted rti
vector_valid  out  1  1-cycle pulse: vector is to be loaded into pc
vector  out  16  handler address; valid only while vector_valid=1
busy  out  1  depth != 0 (equivalent of processing_interrupt)
depth  out  $clog2(NEST_DEPTH+1)  number of currently active handlers
active_id  out  $clog2(N_IRQ)  channel on top of the stack; 0 when depth=0

Behaviour:
- Reset (asynchronous, rst_n=0): every output is 0. pending=0, stack empty, mask=MASK_RESET, edge-detect history=0, state=IDLE.
- Edge detection: irq is registered once. pending[i] is set when irq[i]=1 and the previous sample was 0. The set takes priority over a clear of the same bit in the same cycle.
- Eligibility: eligible = pending & mask.
  - At depth=0, all channels are eligible.
  - At depth>0, only ids strictly lower than active_id are eligible.
  - No channel is eligible when depth=NEST_DEPTH.
- Winner: the lowest-index eligible bit.
- State machine: IDLE -> SAVE -> VECTOR -> IDLE, plus IDLE -> RESTORE -> IDLE.
  - IDLE: check=1 with any eligible bit moves to SAVE and captures the winner id. check=1 with nothing eligible stays in IDLE and produces no outputs. rti=1 with depth>0 moves to RESTORE. rti=1 with depth=0 is ignored.
  - SAVE (1 cycle): take=1 and save_state=1. pending[id] is cleared, id is pushed, depth is incremented.
  - VECTOR (1 cycle): vector_valid=1. vector = VECTOR_BASE + id*VECTOR_STRIDE, computed in 16 bits with wrap-around.
  - RESTORE (1 cycle): restore_state=1, the stack is popped, depth is decremented.
- Simultaneous check and rti in IDLE: rti wins and check is dropped. The FSM re-checks after RESTORE.
- check or rti outside IDLE is ignored.
- A mask write takes effect on the next cycle. Masking never clears pending.
- Latency: check at cycle t gives take/save_state at t+1 and vector_valid at t+2. rti at t gives restore_state at t+1.
- Reset mid-sequence aborts immediately. No partial pulse is emitted after rst_n deasserts.

Optional Feature:
IRQ_NEST_EN
- Defined: nesting up to NEST_DEPTH, with the priority rule above.
- Undefined: effective depth is 1 and NEST_DEPTH is ignored. No channel is eligible while busy=1; this is the legacy single-level behaviour. The stack reduces to a single id register.

Decomposition:
- Package irq_pkg holds:
  - irq_state_t enum {IRQ_IDLE, IRQ_SAVE, IRQ_VECTOR, IRQ_RESTORE}
  - localparam VECTOR_W=16
  - helper function irq_vector(base, id, stride)
- Sub-module irq_priority_enc (N_IRQ): combinational; takes the eligible vector and outputs found plus the lowest-index id.

Test Plan:
- Basic take: defaults; irq[2] rising, then check -> take=save_state=1 next cycle, vector_valid=1 with vector=16'd14 the cycle after, busy=1, depth=1, active_id=2.
- Priority and return: irq[1] and irq[3] rise together, then check -> vector=7. Then rti -> restore_state=1 and depth=0. Then check -> vector=21.
- Masking: mask=4'b1110, irq[0] rises, check -> no take. Set mask=4'b1111, check -> take, vector=0.
- Nesting (IRQ_NEST_EN): active id 3. irq[1] + check -> vector=7, depth=2. irq[2] + check -> no take. rti -> depth=1, active_id=3. check -> vector=14, depth=2.
- Boundary cases:
  - rti at depth 0 -> no restore_state, depth stays 0.
  - NEST_DEPTH=1 full: check with pending -> no take.
  - Without the macro, busy=1 blocks irq[0].
- Reset mid-SAVE: rst_n low during SAVE -> all outputs 0 at once, pending=0, and no vector_valid after release.
